// File: rtl/raid_read_recover.sv
// RAID read client: fetches D0/D1 Hamming(12,8) words, corrects them,
// and rebuilds one uncorrectable word from the parity disk.
module raid_read_recover #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              raid_out_valid,
   output logic [ADDR_W-1:0] raid_add,
   output logic [1:0]        raid_en_rd_mem,
   input  logic              raid_mem_valid,
   input  logic [11:0]       raid_rd_valid_data_A,
   input  logic [11:0]       raid_rd_valid_data_B,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [7:0]        rsp_data0,
   output logic [7:0]        rsp_data1,
   output logic [1:0]        rsp_status,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  fail_cnt
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, RD1, WAIT1, DEC1, RD2, WAIT2, REBUILD, RESP
   } state_t;

   state_t state, state_nx;

   logic              live;
   logic [ADDR_W-1:0] addr_q;
   logic [11:0]       cap_a, cap_b, cap_p;
   logic [TW-1:0]     tcnt;
   logic [7:0]        d0_q, d1_q;
   logic [1:0]        st_q;

   logic       ld, cap1, cap2, fail_inc;
   logic [7:0] ld_d0, ld_d1;
   logic [1:0] ld_st, corr_inc;

   logic [3:0]  sa, sb, sp, sr;
   logic [11:0] fa, fb, fp, good, rb;
   logic        ua, ub, ca, cb, p_unc;

   function automatic logic [3:0] syn(input logic [11:0] c);
      logic [3:0] s;
      s = '0;
      for (int i = 1; i <= 12; i++)
         if (c[i-1]) s = s ^ 4'(i);
      return s;
   endfunction

   function automatic logic [11:0] fix(input logic [11:0] c);
      logic [3:0]  s;
      logic [11:0] r;
      s = syn(c);
      r = c;
      if (s != 4'd0 && s <= 4'd12) r[s-4'd1] = ~r[s-4'd1];
      return r;
   endfunction

   function automatic logic [7:0] dat(input logic [11:0] c);
      return {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0] a,
      input logic [1:0]       b
   );
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   assign sa    = syn(cap_a);
   assign sb    = syn(cap_b);
   assign sp    = syn(cap_p);
   assign fa    = fix(cap_a);
   assign fb    = fix(cap_b);
   assign fp    = fix(cap_p);
   assign ua    = sa > 4'd12;
   assign ub    = sb > 4'd12;
   assign p_unc = sp > 4'd12;
   assign ca    = (sa != 4'd0) && !ua;
   assign cb    = (sb != 4'd0) && !ub;
   assign good  = ua ? fb : fa;
   assign rb    = fp ^ good;
   assign sr    = syn(rb);

   assign fail_inc = ld && (ld_st == 2'b11);

   // Next-state, capture strobes and response load values
   always_comb begin
      state_nx = state;
      ld       = 1'b0;
      ld_d0    = '0;
      ld_d1    = '0;
      ld_st    = '0;
      cap1     = 1'b0;
      cap2     = 1'b0;
      corr_inc = '0;
      unique case (state)
         IDLE:
            if (req_valid && live) state_nx = RD1;
         RD1:
            state_nx = WAIT1;
         WAIT1:
            if (raid_mem_valid) begin
               cap1     = 1'b1;
               state_nx = DEC1;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               ld       = 1'b1;
               ld_st    = 2'b11;
               state_nx = RESP;
            end
         DEC1: begin
            corr_inc = {1'b0, ca} + {1'b0, cb};
            if (ua && ub) begin
               ld       = 1'b1;
               ld_st    = 2'b11;
               state_nx = RESP;
            end else if (ua || ub) begin
               state_nx = RD2;
            end else begin
               ld       = 1'b1;
               ld_d0    = dat(fa);
               ld_d1    = dat(fb);
               ld_st    = (ca || cb) ? 2'b01 : 2'b00;
               state_nx = RESP;
            end
         end
         RD2:
            state_nx = WAIT2;
         WAIT2:
            if (raid_mem_valid) begin
               cap2     = 1'b1;
               state_nx = REBUILD;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               ld       = 1'b1;
               ld_st    = 2'b11;
               state_nx = RESP;
            end
         REBUILD: begin
            ld       = 1'b1;
            state_nx = RESP;
            if (!p_unc && sr == 4'd0) begin
               ld_st = 2'b10;
               ld_d0 = ua ? dat(rb) : dat(fa);
               ld_d1 = ua ? dat(fb) : dat(rb);
            end else begin
               ld_st = 2'b11;
            end
         end
         RESP:
            if (rsp_ready) state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   // State register; live holds req_ready low until the first clock after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         live  <= 1'b0;
      end else begin
         state <= state_nx;
         live  <= 1'b1;
      end
   end

   // Address/capture registers, timeout counter, response and statistics
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         cap_a    <= '0;
         cap_b    <= '0;
         cap_p    <= '0;
         tcnt     <= '0;
         d0_q     <= '0;
         d1_q     <= '0;
         st_q     <= '0;
         corr_cnt <= '0;
         fail_cnt <= '0;
      end else begin
         if (state == IDLE && req_valid && live) addr_q <= req_addr;
         if (cap1) begin
            cap_a <= raid_rd_valid_data_A;
            cap_b <= raid_rd_valid_data_B;
         end
         if (cap2) cap_p <= raid_rd_valid_data_A;
         if (state == RD1 || state == RD2)
            tcnt <= '0;
         else if (state == WAIT1 || state == WAIT2)
            tcnt <= tcnt + TW'(1);
         if (ld) begin
            d0_q <= ld_d0;
            d1_q <= ld_d1;
            st_q <= ld_st;
         end
         corr_cnt <= sat_add(corr_cnt, corr_inc);
         fail_cnt <= sat_add(fail_cnt, {1'b0, fail_inc});
      end
   end

   assign req_ready      = live && (state == IDLE);
   assign raid_out_valid = (state == RD1) || (state == RD2);
   assign raid_add       = (state inside {RD1, WAIT1, DEC1, RD2, WAIT2})
                           ? addr_q : '0;
   assign raid_en_rd_mem = (state inside {RD1, WAIT1, DEC1}) ? 2'b11 :
                           (state inside {RD2, WAIT2, REBUILD}) ? 2'b10 :
                           2'b00;
   assign rsp_valid      = (state == RESP);
   assign rsp_data0      = rsp_valid ? d0_q : '0;
   assign rsp_data1      = rsp_valid ? d1_q : '0;
   assign rsp_status     = rsp_valid ? st_q : '0;

endmodule
